// File: rtl/uart_tx_cfg.sv
// ============================================================================
// Module      : uart_tx_cfg
// Description : Parametrised UART transmitter (5..9 data bits, none/odd/even
//               parity, 1 or 2 stop bits) fed by a synchronous TX FIFO with a
//               valid/ready write port. Line is idle high and registered.
// Revision    : 1.0 - initial release, successor to fixed 8N1 uart_tx
// ============================================================================
`default_nettype none

module uart_tx_cfg #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_BITS-1:0]          i_data,
    input  logic                          i_valid,
    output logic                          o_ready,
    output logic                          o_drop,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_uart_tx,
    output logic                          o_busy
);

    // Rounded clocks-per-bit
    localparam int BAUD_DIV = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int CW       = $clog2(BAUD_DIV + 1);
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int LW       = AW + 1;

    // Reject unsupported frame formats when the design is elaborated
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_cfg: FIFO_DEPTH must be a power of 2, at least 2");
    end
    if (BAUD_DIV < 1) begin : g_bad_baud
        $error("uart_tx_cfg: BAUD too high for CLK_FREQ");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;

    // FIFO storage and bookkeeping
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [LW-1:0]        level;

    // Transmitter state
    state_t               state;
    logic [CW-1:0]        baud_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 tx_line;

    logic ready;
    logic push;
    logic pop;
    logic baud_end;
    logic stop_last;
    logic [DATA_BITS-1:0] head;

    // Parity bit that completes the requested odd/even count of ones
    function automatic logic parity_of(input logic [DATA_BITS-1:0] w);
        return (PARITY == 1) ? ~(^w) : (^w);
    endfunction

    assign ready     = (level != LW'(FIFO_DEPTH));
    assign push      = i_valid && ready;
    assign baud_end  = (baud_cnt == CW'(BAUD_DIV - 1));
    assign stop_last = (bit_cnt == 4'(STOP_BITS - 1));
    // A new frame is loaded either from IDLE or straight out of the last stop bit
    assign pop       = (level != '0) &&
                       ((state == IDLE) || ((state == STOP) && baud_end && stop_last));
    assign head      = mem[rd_ptr];

    assign o_ready      = ready;
    assign o_drop       = rst_n && i_valid && !ready;
    assign o_fifo_level = level;
    assign o_uart_tx    = tx_line;
    assign o_busy       = (state != IDLE) || (level != '0);

    // FIFO data array write port
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop keep the level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push) begin
                level <= level - LW'(1);
            end
        end
    end

    // Frame sequencer: start, data LSB first, optional parity, stop bits
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx_line  <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tx_line  <= 1'b1;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (pop) begin
                        shreg   <= head;
                        par_bit <= parity_of(head);
                        tx_line <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx_line  <= shreg[0];
                        shreg    <= shreg >> 1;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 4'(DATA_BITS - 1)) begin
                            bit_cnt <= '0;
                            if (PARITY != 0) begin
                                tx_line <= par_bit;
                                state   <= PAR;
                            end else begin
                                tx_line <= 1'b1;
                                state   <= STOP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            tx_line <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                PAR: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx_line  <= 1'b1;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (stop_last) begin
                            bit_cnt <= '0;
                            if (pop) begin
                                shreg   <= head;
                                par_bit <= parity_of(head);
                                tx_line <= 1'b0;
                                state   <= START;
                            end else begin
                                state   <= IDLE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                default: begin
                    tx_line <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART transmitter and successor to the fixed 8N1 uart_tx. Data bits, parity mode, stop-bit count and baud rate are set at elaboration. A synchronous TX FIFO with a valid/ready write port lets the host burst words. Sits between the host/loopback logic and the board TX pin.

Parameters:
CLK_FREQ, 50000000, clk frequency in Hz
BAUD, 115200, line baud rate
DATA_BITS, 8, data bits per frame, legal range 5..9
PARITY, 0, parity mode: 0 none, 1 odd, 2 even
STOP_BITS, 1, stop bits per frame, 1 or 2
FIFO_DEPTH, 16, TX FIFO depth in words, power of 2, at least 2

Ports:
clk  input  1  system clock
rst_n  input  1  reset, synchronous, active-low
i_data  input  DATA_BITS  word to transmit
i_valid  input  1  write request
o_ready  output  1  FIFO can accept a word (not full)
o_drop  output  1  1-cycle pulse when i_valid is high while o_ready is low
o_fifo_level  output  $clog2(FIFO_DEPTH)+1  words currently stored
o_uart_tx  output  1  serial line, idle high, registered
o_busy  output  1  frame in progress or FIFO not empty

Behaviour:
- Reset (rst_n low at a clk edge): o_uart_tx=1, o_busy=0, o_fifo_level=0, o_ready=1, o_drop=0. FSM returns to IDLE, the FIFO is flushed and the baud counter is cleared.
- Reset mid-frame: the line goes high at the reset edge and the partial frame is abandoned.
- Baud divisor: BAUD_DIV = (CLK_FREQ + BAUD/2)/BAUD, computed at elaboration. Every line bit is held exactly BAUD_DIV clk cycles.
- Write handshake: a word is accepted on an edge where i_valid && o_ready.
  - o_ready = (level != FIFO_DEPTH), derived combinationally from the registered level.
  - A rejected write is discarded, o_drop pulses high for that cycle, and the level is unchanged.
- Push and pop on the same edge leave the level unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM states are IDLE, START, DATA, PAR and STOP.
  - IDLE: line high. If level > 0, pop the head word into the shift register, drive the line 0 and go to START.
  - START: after BAUD_DIV cycles go to DATA.
  - DATA: send bits LSB first, DATA_BITS bits in total. Then go to PAR if PARITY != 0, else go to STOP.
  - PAR: odd mode sends a bit that makes the total ones in data+parity odd; even mode makes the total even. Hold for BAUD_DIV cycles, then go to STOP.
  - STOP: line high for STOP_BITS*BAUD_DIV cycles. At the end:
    - if level > 0, pop and go straight to START (no idle gap);
    - else go to IDLE.
- Latency: a word written at edge E into an empty FIFO with the FSM in IDLE drives the line low from edge E+1.
- Frame length = (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * BAUD_DIV cycles.
- o_busy is high whenever the FSM is not IDLE or level > 0. It falls on the edge where STOP completes with the FIFO empty.
- A write arriving in the same cycle that STOP completes with an otherwise empty FIFO is stored. It is popped on the next edge through IDLE, giving a 1-cycle idle gap.
- Illegal parameter values (DATA_BITS out of range, PARITY > 2, STOP_BITS not 1 or 2) are an elaboration-time error.

Test Plan:
- Frame 0x3D, 8N1, CLK_FREQ=1000000, BAUD=100000 (BAUD_DIV=10). Expected: start at E+1, then bits 1,0,1,1,1,1,0,0 LSB first, 10 cycles each. Stop high 10 cycles, o_busy falls at cycle 100 after start.
- PARITY=2 and PARITY=1 with 0x3D (five ones). Expected parity bit 1 for even and 0 for odd; frame is 110 cycles.
- DATA_BITS=7, STOP_BITS=2, word 0x55. Expected line 0,1,0,1,0,1,0,1 then two stop bits; frame is 100 cycles.
- Write 3 words back-to-back (0x01, 0x02, 0x03), 8N1. Expected three contiguous frames with no high gap between stop and next start; level goes 1,2,... then drains to 0.
- Hold i_valid high for 20 consecutive cycles with FIFO_DEPTH=16 while the first frame transmits. Expected: level saturates at 16, o_ready=0, o_drop pulses on the rejected cycles, and all 17 accepted words are transmitted in order.
- Assert rst_n=0 during DATA bit 3 with 2 words queued. Expected: next edge gives o_uart_tx=1, level=0, o_busy=0; no further frames are sent after release.
